// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//
// Write-back stage. It merges the ALU, LSU, MUL and DIV execution pipes onto
// the single register-file write port (wr_en / wr_rd / wr_data).
//
// The dispatcher schedules the fixed-latency pipes (ALU, LSU, MUL) so that
// they never collide. They always win the port, in priority MUL > LSU > ALU.
// The serial divider hands its result to a one-entry holding buffer. The
// buffer is written out in the first cycle in which no fixed pipe is writing.
//
// A starvation counter tracks how long a buffered DIV result has waited.
// Once the wait reaches STARVE_LIMIT cycles, wb_hold asks the core to stop
// dispatching so the buffer can drain.
//
// Build option:
//   WB_COLLISION_CHECK_EN - when defined, simultaneous fixed-pipe results set
//                           the sticky collision_err flag. When undefined,
//                           collision_err is tied low. Result selection is
//                           identical in both builds.

module writeback_arbiter #(
    parameter int NUM_REGS     = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int REG_AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_div,

    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [31:0]       alu_data,

    input  logic              lsu_valid,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [31:0]       lsu_data,

    input  logic              mul_valid,
    input  logic [REG_AW-1:0] mul_rd,
    input  logic [31:0]       mul_data,

    input  logic              div_valid,
    output logic              div_ready,
    input  logic [REG_AW-1:0] div_rd,
    input  logic [31:0]       div_data,

    output logic              wr_en,
    output logic [REG_AW-1:0] wr_rd,
    output logic [31:0]       wr_data,
    output logic              div_done,
    output logic              wb_hold,
    output logic              collision_err
);

    // Counter wide enough to hold STARVE_LIMIT itself (saturating value).
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              buf_valid;
    logic [REG_AW-1:0] buf_rd;
    logic [31:0]       buf_data;
    logic [CW-1:0]     starve_cnt;

    // Fixed-pipe selection result
    logic              fix_valid;
    logic [REG_AW-1:0] fix_rd;
    logic [31:0]       fix_data;

    logic              div_accept;
    logic              drain;

    // The divider can hand over only while the buffer is empty. div_ready
    // comes straight from the flop, so a drain never frees the slot for a
    // refill in the same cycle.
    assign div_ready = ~buf_valid;

    // A flush takes priority over accepting a new DIV result.
    assign div_accept = div_valid && div_ready && !flush_div;

    // The buffer drains only into a slot no fixed pipe is using, and a flush
    // cancels the drain.
    assign drain = buf_valid && !fix_valid && !flush_div;

    // Fixed-pipe priority mux: MUL over LSU over ALU; losers are dropped.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        fix_valid = 1'b0;
        fix_rd    = '0;
        fix_data  = '0;
        if (mul_valid) begin
            fix_valid = 1'b1;
            fix_rd    = mul_rd;
            fix_data  = mul_data;
        end else if (lsu_valid) begin
            fix_valid = 1'b1;
            fix_rd    = lsu_rd;
            fix_data  = lsu_data;
        end else if (alu_valid) begin
            fix_valid = 1'b1;
            fix_rd    = alu_rd;
            fix_data  = alu_data;
        end
    end

    // DIV holding buffer: fill on handshake, empty on drain, flush or reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            buf_valid <= 1'b0;
        end else if (flush_div || drain) begin
            buf_valid <= 1'b0;
        end else if (div_accept) begin
            buf_valid <= 1'b1;
        end
    end

    // Buffer payload loads on accept; it needs no reset because buf_valid qualifies it.
    always_ff @(posedge clk) begin
        // NOTE: datapath storage guarded by a valid bit is deliberately left unreset.
        if (div_accept) begin
            buf_rd   <= div_rd;
            buf_data <= div_data;
        end
    end

    // Starvation counter: count cycles the buffered result is kept waiting.
    always_ff @(posedge clk) begin
        if (rst || flush_div || drain || !buf_valid) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Registered dispatch-hold request, raised once the counter has saturated.
    always_ff @(posedge clk) begin
        if (rst || flush_div || drain) begin
            wb_hold <= 1'b0;
        end else begin
            wb_hold <= (starve_cnt == LIMIT);
        end
    end

    // Write-port register: a fixed pipe wins, otherwise drain the DIV buffer.
    // x0 is never written, but the address and data still update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en    <= 1'b0;
            wr_rd    <= '0;
            wr_data  <= '0;
            div_done <= 1'b0;
        end else if (fix_valid) begin
            wr_en    <= (fix_rd != '0);
            wr_rd    <= fix_rd;
            wr_data  <= fix_data;
            div_done <= 1'b0;
        end else if (drain) begin
            wr_en    <= (buf_rd != '0);
            wr_rd    <= buf_rd;
            wr_data  <= buf_data;
            div_done <= 1'b1;
        end else begin
            wr_en    <= 1'b0;
            div_done <= 1'b0;
        end
    end

`ifdef WB_COLLISION_CHECK_EN
    logic multi_fix;

    // True whenever at least two fixed pipes present a result together.
    assign multi_fix = (alu_valid && lsu_valid) ||
                       (alu_valid && mul_valid) ||
                       (lsu_valid && mul_valid);

    // Sticky collision flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            collision_err <= 1'b0;
        end else if (multi_fix) begin
            collision_err <= 1'b1;
        end
    end
`else
    assign collision_err = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter.
// Expected register-file writes go into a scoreboard queue tagged with the
// cycle in which they must appear. A monitor pops and compares each write
// the DUT presents. Level outputs (div_ready, wb_hold, collision_err) are
// checked in line with the directed stimulus.

module tb_writeback_arbiter;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_div;
    logic          alu_valid, lsu_valid, mul_valid, div_valid;
    logic [AW-1:0] alu_rd, lsu_rd, mul_rd, div_rd;
    logic [31:0]   alu_data, lsu_data, mul_data, div_data;
    logic          div_ready, wr_en, div_done, wb_hold, collision_err;
    logic [AW-1:0] wr_rd;
    logic [31:0]   wr_data;

    typedef struct {
        int          cyc;
        logic        en;
        logic [AW-1:0] rd;
        logic [31:0] data;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    writeback_arbiter #(.NUM_REGS(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .flush_div(flush_div),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .mul_valid(mul_valid), .mul_rd(mul_rd), .mul_data(mul_data),
        .div_valid(div_valid), .div_ready(div_ready),
        .div_rd(div_rd), .div_data(div_data),
        .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
        .div_done(div_done), .wb_hold(wb_hold), .collision_err(collision_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic en, input logic [AW-1:0] rd,
                        input logic [31:0] data, input logic done);
        exp_t e;
        e.cyc = c; e.en = en; e.rd = rd; e.data = data; e.done = done;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        flush_div = 0;
        alu_valid = 0; lsu_valid = 0; mul_valid = 0; div_valid = 0;
        alu_rd = 0; lsu_rd = 0; mul_rd = 0; div_rd = 0;
        alu_data = 0; lsu_data = 0; mul_data = 0; div_data = 0;
    endtask

    // Monitor: every presented write or div_done must match the queue head.
    always @(negedge clk) begin
        if (!rst && (wr_en || div_done)) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {wr_en, div_done}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_cycle", cyc, e.cyc);
                check("wb_en", wr_en, e.en);
                check("wb_rd", wr_rd, e.rd);
                check("wb_data", wr_data, e.data);
                check("wb_div_done", div_done, e.done);
            end
        end
    end

    initial begin
        idle_inputs();
        rst = 1;
        repeat (3) step();
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_rd", wr_rd, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_div_done", div_done, 0);
        check("rst_wb_hold", wb_hold, 0);
        check("rst_collision", collision_err, 0);
        check("rst_div_ready", div_ready, 1);
        rst = 0;
        step();

        // ALU write to r5
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF;
        push(cyc + 1, 1, 5, 32'hDEAD_BEEF, 0);
        step();
        idle_inputs();
        step();

        // DIV with idle pipes: buffered at N+1, written at N+2
        check("div_ready_before", div_ready, 1);
        div_valid = 1; div_rd = 7; div_data = 32'h12;
        push(cyc + 2, 1, 7, 32'h12, 1);
        step();
        idle_inputs();
        check("div_ready_n1", div_ready, 0);
        step();
        step();
        check("div_ready_n3", div_ready, 1);
        step();

        // Starvation: DIV buffered while MUL writes for 6 cycles
        div_valid = 1; div_rd = 9; div_data = 32'h99;
        step();
        div_valid = 0;
        for (int i = 1; i <= 6; i++) begin
            check("starve_hold", wb_hold, (i >= 6) ? 1 : 0);
            mul_valid = 1; mul_rd = 10; mul_data = 32'h100 + i;
            push(cyc + 1, 1, 10, 32'h100 + i, 0);
            step();
        end
        mul_valid = 0;
        check("starve_hold_last", wb_hold, 1);
        check("starve_ready", div_ready, 0);
        push(cyc + 1, 1, 9, 32'h99, 1);
        step();
        check("starve_hold_fall", wb_hold, 0);
        step();
        check("starve_ready_back", div_ready, 1);

        // Flush: starve first so wb_hold is set, then discard
        div_valid = 1; div_rd = 11; div_data = 32'hBAD;
        step();
        div_valid = 0;
        for (int i = 1; i <= 6; i++) begin
            mul_valid = 1; mul_rd = 12; mul_data = 32'h200 + i;
            push(cyc + 1, 1, 12, 32'h200 + i, 0);
            step();
        end
        mul_valid = 0;
        check("flush_hold_before", wb_hold, 1);
        flush_div = 1;
        step();
        check("flush_hold_after", wb_hold, 0);
        check("flush_ready_after", div_ready, 1);
        // Flush together with div_valid on an empty buffer: not captured
        div_valid = 1; div_rd = 13; div_data = 32'h1313;
        step();
        idle_inputs();
        check("flush_wins_ready", div_ready, 1);
        repeat (3) step();

        // Writes to x0
        alu_valid = 1; alu_rd = 0; alu_data = 32'hCAFE_0000;
        step();
        idle_inputs();
        check("x0_wr_en", wr_en, 0);
        check("x0_wr_rd", wr_rd, 0);
        check("x0_wr_data", wr_data, 32'hCAFE_0000);
        div_valid = 1; div_rd = 0; div_data = 32'h55;
        push(cyc + 2, 0, 0, 32'h55, 1);
        step();
        idle_inputs();
        repeat (3) step();

        // Collision: ALU and MUL together, MUL wins
        alu_valid = 1; alu_rd = 3; alu_data = 32'h3333;
        mul_valid = 1; mul_rd = 4; mul_data = 32'h4444;
        push(cyc + 1, 1, 4, 32'h4444, 0);
        step();
        idle_inputs();
`ifdef WB_COLLISION_CHECK_EN
        check("collision_set", collision_err, 1);
`else
        check("collision_set", collision_err, 0);
`endif
        // LSU beats ALU
        alu_valid = 1; alu_rd = 8; alu_data = 32'h8888;
        lsu_valid = 1; lsu_rd = 6; lsu_data = 32'h6666;
        push(cyc + 1, 1, 6, 32'h6666, 0);
        step();
        idle_inputs();
        repeat (3) step();
`ifdef WB_COLLISION_CHECK_EN
        check("collision_sticky", collision_err, 1);
`else
        check("collision_sticky", collision_err, 0);
`endif

        // Reset with a buffered DIV result: dropped, no div_done
        div_valid = 1; div_rd = 14; div_data = 32'hEEEE;
        step();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        check("rst_mid_ready", div_ready, 1);
        check("rst_mid_collision", collision_err, 0);
        check("rst_mid_wr_en", wr_en, 0);
        repeat (5) step();

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
